// File: rtl/param_acc_cpu_pkg.sv
// Shared types for the accumulator CPU: opcode and FSM state encodings.
package param_acc_cpu_pkg;

  // Width of the opcode field held in the top bits of every instruction.
  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LDA_I = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_LDB_I = 4'h8,
    OP_STA   = 4'h9,
    OP_LDA_M = 4'hA,
    OP_JMP   = 4'hB,
    OP_BEQ   = 4'hC,
    OP_BNE   = 4'hD,
    OP_BCS   = 4'hE,
    OP_HLT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_e;

endpackage

// File: rtl/param_acc_cpu_if.sv
// Control, program-load and status signals of the accumulator CPU.
interface param_acc_cpu_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              en;
  logic              start;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [DATA_W-1:0] acc_out;
  logic [ADDR_W-1:0] pc_out;
  logic              flag_z;
  logic              flag_c;
  logic              halted;

  modport master (
    output en, start, ld_valid, ld_addr, ld_data,
    input  ld_ready, acc_out, pc_out, flag_z, flag_c, halted
  );

  modport slave (
    input  en, start, ld_valid, ld_addr, ld_data,
    output ld_ready, acc_out, pc_out, flag_z, flag_c, halted
  );
endinterface

// File: rtl/param_acc_cpu_ram.sv
// Unified program/data memory: one synchronous write port, two async read ports.
module param_acc_cpu_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port shared by program load and STA.
  // NOTE: the array has no reset so a loaded program survives rst and maps to plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/param_acc_cpu.sv
// Multi-cycle accumulator CPU with program-load port.
module param_acc_cpu
  import param_acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  param_acc_cpu_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, b_q, b_d, ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              c_q, c_d, z_q, z_d;

  opcode_e           opc;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] rd_pc, rd_op, acc_new;
  logic [DATA_W:0]   sum;
  logic              acc_wr, sta_we, ld_we;

  assign opc     = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
  assign op_addr = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, b_q};

  assign bus.ld_ready = ~bus.en | (state_q == S_HALT);
  assign ld_we        = bus.ld_valid & bus.ld_ready;

  // Loads and STA never overlap: loads need ld_ready, STA needs a running CPU.
  param_acc_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we      (ld_we | sta_we),
    .waddr   (ld_we ? bus.ld_addr : op_addr),
    .wdata   (ld_we ? bus.ld_data : acc_q),
    .ra_addr (pc_q),
    .ra_data (rd_pc),
    .rb_addr (op_addr),
    .rb_data (rd_op)
  );

  // Next-state and datapath: restart, stall, or advance one FSM step.
  // NOTE: every signal gets a hold/idle default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    c_d     = c_q;
    z_d     = z_q;
    acc_new = '0;
    acc_wr  = 1'b0;
    sta_we  = 1'b0;

    if (bus.start) begin
      pc_d    = '0;
      state_d = S_FETCH;
    end else if (bus.en && state_q != S_HALT) begin
      unique case (state_q)
        S_FETCH: begin
          ir_d    = rd_pc;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          state_d = (opc == OP_LDA_I || opc == OP_LDB_I) ? S_OPERAND : S_EXEC;
        end
        S_OPERAND: begin
          pc_d = pc_q + 1'b1;
          if (opc == OP_LDA_I) begin
            acc_new = rd_pc;
            acc_wr  = 1'b1;
          end else begin
            b_d = rd_pc;
          end
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          case (opc)
            OP_ADD:   begin {c_d, acc_new} = sum;           acc_wr = 1'b1; end
            OP_SUB:   begin acc_new = acc_q - b_q;
                            c_d = (acc_q < b_q);            acc_wr = 1'b1; end
            OP_AND:   begin acc_new = acc_q & b_q;          acc_wr = 1'b1; end
            OP_OR:    begin acc_new = acc_q | b_q;          acc_wr = 1'b1; end
            OP_XOR:   begin acc_new = acc_q ^ b_q;          acc_wr = 1'b1; end
            OP_NOT:   begin acc_new = ~acc_q;               acc_wr = 1'b1; end
            OP_LDA_M: begin acc_new = rd_op;                acc_wr = 1'b1; end
            OP_STA:   sta_we = 1'b1;
            OP_JMP:   pc_d = op_addr;
            OP_BEQ:   if (z_q)  pc_d = op_addr;
            OP_BNE:   if (!z_q) pc_d = op_addr;
            OP_BCS:   if (c_q)  pc_d = op_addr;
            OP_HLT:   state_d = S_HALT;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end

    if (acc_wr) begin
      acc_d = acc_new;
      z_d   = (acc_new == '0);
    end
  end

  // Architectural state register with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      acc_q   <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  assign bus.acc_out = acc_q;
  assign bus.pc_out  = pc_q;
  assign bus.flag_z  = z_q;
  assign bus.flag_c  = c_q;
  assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_param_acc_cpu.sv
// Directed bench for param_acc_cpu: program table plus corner-case sequences.
module tb_param_acc_cpu;
  import param_acc_cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_acc_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  param_acc_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [0:15][7:0] prog_t;

  typedef struct {
    string      name;
    prog_t      prog;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.start = 1'b0; bus.ld_valid = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic load_prog(input prog_t p);
    bus.en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 4'(i);
      bus.ld_data  = p[i];
      step(1);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int k = 0;
    while (!bus.halted && k < budget) begin
      step(1);
      k++;
    end
    check({name, "_halt"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    vecs[0] = '{name: "add_carry",
                prog: {8'h10, 8'hFF, 8'h80, 8'h01, 8'h20, 8'hF0, {10{8'h00}}},
                acc: 8'h00, c: 1'b1, z: 1'b1, pc: 4'h6};
    vecs[1] = '{name: "sub_bcs",
                prog: {8'h10, 8'h05, 8'h80, 8'h07, 8'h30, 8'hE6, 8'hF0, {9{8'h00}}},
                acc: 8'hFE, c: 1'b1, z: 1'b0, pc: 4'h7};
    vecs[2] = '{name: "logic_ops",
                prog: {8'h10, 8'h0F, 8'h80, 8'h3C, 8'h40, 8'h50, 8'h60, 8'h70, 8'hF0, {7{8'h00}}},
                acc: 8'hFF, c: 1'b0, z: 1'b0, pc: 4'h9};
    vecs[3] = '{name: "sta_lda_beq_bne",
                prog: {8'h10, 8'hA5, 8'h9E, 8'h10, 8'h00, 8'hC8, 8'hF0, 8'hF0,
                       8'hAE, 8'hDC, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00},
                acc: 8'hA5, c: 1'b0, z: 1'b0, pc: 4'hD};
    vecs[4] = '{name: "sub_nobcs_jmp",
                prog: {8'h10, 8'h09, 8'h80, 8'h03, 8'h30, 8'hE9, 8'hBA, 8'hF0,
                       8'hF0, 8'hF0, 8'hF0, {5{8'h00}}},
                acc: 8'h06, c: 1'b0, z: 1'b0, pc: 4'hB};

    // Reset state, sampled while reset is held.
    bus.en = 1'b0; bus.start = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_addr = '0; bus.ld_data = '0;
    rst = 1'b1;
    step(2);
    check("rst_acc",      32'(bus.acc_out),  32'h0);
    check("rst_pc",       32'(bus.pc_out),   32'h0);
    check("rst_z",        32'(bus.flag_z),   32'h0);
    check("rst_c",        32'(bus.flag_c),   32'h0);
    check("rst_halted",   32'(bus.halted),   32'h0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'h1);
    rst = 1'b0;

    // Table-driven programs, each from a clean reset.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load_prog(vecs[v].prog);
      pulse_start();
      wait_halt(vecs[v].name, 200);
      check({vecs[v].name, "_acc"}, 32'(bus.acc_out), 32'(vecs[v].acc));
      check({vecs[v].name, "_c"},   32'(bus.flag_c),  32'(vecs[v].c));
      check({vecs[v].name, "_z"},   32'(bus.flag_z),  32'(vecs[v].z));
      check({vecs[v].name, "_pc"},  32'(bus.pc_out),  32'(vecs[v].pc));
      if (v == 3) check("sta_mem_e", 32'(dut.u_ram.mem_q[14]), 32'hA5);
    end

    // 16 NOPs: 16th fetch lands on run edge 46, PC wraps F -> 0.
    do_reset();
    load_prog('0);
    pulse_start();
    step(45);
    check("nop_pc_before_wrap", 32'(bus.pc_out), 32'hF);
    step(3);
    check("nop_pc_wrapped", 32'(bus.pc_out), 32'h0);
    check("nop_not_halted", 32'(bus.halted), 32'h0);

    // Stall during OPERAND of LDA #33.
    do_reset();
    load_prog({8'h10, 8'h33, 8'hF0, {13{8'h00}}});
    pulse_start();
    step(2);
    bus.en = 1'b0;
    step(5);
    check("frz_acc", 32'(bus.acc_out), 32'h00);
    check("frz_pc",  32'(bus.pc_out),  32'h1);
    check("frz_halted", 32'(bus.halted), 32'h0);
    bus.en = 1'b1;
    step(1);
    check("frz_acc_resume", 32'(bus.acc_out), 32'h33);
    check("frz_pc_resume",  32'(bus.pc_out),  32'h2);
    wait_halt("frz", 50);
    check("frz_pc_end", 32'(bus.pc_out), 32'h3);

    // Load attempted while running, then again after HLT.
    do_reset();
    load_prog({8'h00, 8'h00, 8'hF0, {13{8'h00}}});
    pulse_start();
    step(1);
    bus.ld_valid = 1'b1; bus.ld_addr = 4'h3; bus.ld_data = 8'hAA;
    #1 check("run_ld_ready", 32'(bus.ld_ready), 32'h0);
    step(1);
    bus.ld_valid = 1'b0;
    check("run_ld_ignored", 32'(dut.u_ram.mem_q[3]), 32'h00);
    wait_halt("ld", 50);
    check("halt_ld_ready", 32'(bus.ld_ready), 32'h1);
    bus.ld_valid = 1'b1; bus.ld_addr = 4'h3; bus.ld_data = 8'hAA;
    step(1);
    bus.ld_valid = 1'b0;
    check("halt_ld_written", 32'(dut.u_ram.mem_q[3]), 32'hAA);
    check("halt_still_halted", 32'(bus.halted), 32'h1);

    // Reset during EXEC of STA 7 with ACC=5A.
    do_reset();
    load_prog({8'h10, 8'h5A, 8'h97, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h11, {8{8'h00}}});
    pulse_start();
    step(6);
    check("sta_pre_acc", 32'(bus.acc_out), 32'h5A);
    rst = 1'b1;
    #1;
    check("sta_rst_acc",    32'(bus.acc_out), 32'h0);
    check("sta_rst_pc",     32'(bus.pc_out),  32'h0);
    check("sta_rst_z",      32'(bus.flag_z),  32'h0);
    check("sta_rst_c",      32'(bus.flag_c),  32'h0);
    check("sta_rst_halted", 32'(bus.halted),  32'h0);
    check("sta_rst_state",  32'(dut.state_q), 32'(S_FETCH));
    step(1);
    rst = 1'b0;
    check("sta_rst_mem7", 32'(dut.u_ram.mem_q[7]), 32'h11);
    check("sta_rst_prog_kept", 32'(dut.u_ram.mem_q[0]), 32'h10);
    pulse_start();
    wait_halt("sta_rerun", 50);
    check("sta_rerun_mem7", 32'(dut.u_ram.mem_q[7]), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
